// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP VRAM arbiter and its CPU access queue.
package vdp_pkg;

    localparam int VRAM_AW            = 14;
    localparam int VRAM_DW            = 8;
    localparam int RENDER_CAPTURE_DLY = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_PEND,
        RD_PEND,
        RD_WAIT1,
        RD_WAIT2
    } cpu_state_t;

endpackage

// File: rtl/vdp_vram_cpu_queue.sv
// CPU data-port side of the VRAM arbiter: single-entry access queue, auto-increment
// address counter and the read-ahead buffer returned on data-port reads.
module vdp_vram_cpu_queue
    import vdp_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_addr_set,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_prefetch,
    input  logic          cpu_wr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_rd,
    input  logic          grant,
    input  logic [DW-1:0] mem_dout,
    output logic          req,
    output logic          req_we,
    output logic [AW-1:0] req_addr,
    output logic [DW-1:0] req_data,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_busy
);

    cpu_state_t    state, state_next;
    logic [AW-1:0] addr_cnt, addr_next;
    logic [AW-1:0] lat_addr, lat_addr_next;
    logic [DW-1:0] lat_data, lat_data_next;
    logic [DW-1:0] rdata_next;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_next;
            addr_cnt  <= addr_next;
            cpu_rdata <= rdata_next;
        end
    end

    // The latched entry is only meaningful while a request is pending.
    always_ff @(posedge clk_sys) begin
        lat_addr <= lat_addr_next;
        lat_data <= lat_data_next;
    end

    always_comb begin
        state_next    = state;
        addr_next     = addr_cnt;
        lat_addr_next = lat_addr;
        lat_data_next = lat_data;
        rdata_next    = cpu_rdata;
        if (cpu_addr_set) begin
            if (cpu_prefetch) begin
                lat_addr_next = cpu_addr;
                addr_next     = cpu_addr + 1'b1;
                state_next    = RD_PEND;
            end else begin
                // Reads in progress are abandoned; a pending write still lands.
                addr_next  = cpu_addr;
                state_next = (state == WR_PEND && !grant) ? WR_PEND : IDLE;
            end
        end else if (cpu_wr) begin
            lat_addr_next = addr_cnt;
            lat_data_next = cpu_wdata;
            rdata_next    = cpu_wdata;
            addr_next     = addr_cnt + 1'b1;
            state_next    = WR_PEND;
        end else if (cpu_rd) begin
            lat_addr_next = addr_cnt;
            addr_next     = addr_cnt + 1'b1;
            state_next    = RD_PEND;
        end else begin
            case (state)
                WR_PEND:  if (grant) state_next = IDLE;
                RD_PEND:  if (grant) state_next = RD_WAIT1;
                RD_WAIT1: state_next = RD_WAIT2;
                RD_WAIT2: begin
                    rdata_next = mem_dout;
                    state_next = IDLE;
                end
                default:  state_next = state;
            endcase
        end
    end

    assign req      = (state == WR_PEND) || (state == RD_PEND);
    assign req_we   = (state == WR_PEND);
    assign req_addr = lat_addr;
    assign req_data = lat_data;
    assign cpu_busy = (state != IDLE);

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM owner: render fetches take every slot they ask for, CPU traffic
// fills idle slots. Optional macro VDP_VRAM_BLANK_FASTPATH_EN grants the CPU any cycle during blank.
module vdp_vram_arbiter
    import vdp_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          render_req,
    input  logic [AW-1:0] render_A,
    output logic [DW-1:0] render_D,
    input  logic          cpu_addr_set,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_prefetch,
    input  logic          cpu_wr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_busy,
    input  logic          blank,
    output logic [AW-1:0] mem_A,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic                          slot_render;
    logic                          grant;
    logic                          cpu_req;
    logic                          cpu_req_we;
    logic [AW-1:0]                 cpu_req_addr;
    logic [DW-1:0]                 cpu_req_data;
    logic [RENDER_CAPTURE_DLY-1:0] render_vld;

    assign slot_render = ce_pix && render_req;

`ifdef VDP_VRAM_BLANK_FASTPATH_EN
    // Outside ce_pix the BRAM port is free while blanked, as long as no render
    // read result is still travelling through the capture pipeline.
    assign grant = (ce_pix && !render_req) ||
                   (blank && !slot_render && (render_vld == '0));
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign grant        = ce_pix && !render_req;
`endif

    vdp_vram_cpu_queue #(
        .AW (AW),
        .DW (DW)
    ) u_cpu_queue (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .cpu_addr_set (cpu_addr_set),
        .cpu_addr     (cpu_addr),
        .cpu_prefetch (cpu_prefetch),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rd       (cpu_rd),
        .grant        (grant),
        .mem_dout     (mem_dout),
        .req          (cpu_req),
        .req_we       (cpu_req_we),
        .req_addr     (cpu_req_addr),
        .req_data     (cpu_req_data),
        .cpu_rdata    (cpu_rdata),
        .cpu_busy     (cpu_busy)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_A      <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
            render_D   <= '0;
            render_vld <= '0;
        end else begin
            mem_we     <= 1'b0;
            render_vld <= {render_vld[RENDER_CAPTURE_DLY-2:0], slot_render};
            if (slot_render) begin
                mem_A <= render_A;
            end else if (grant && cpu_req) begin
                mem_A  <= cpu_req_addr;
                mem_we <= cpu_req_we;
                if (cpu_req_we) mem_din <= cpu_req_data;
            end
            // Capture stage: BRAM data for the render address issued two cycles back.
            if (render_vld[RENDER_CAPTURE_DLY-1]) render_D <= mem_dout;
        end
    end

endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
Responder side of the VDP VRAM read interface: owns the single port of the 16 KB VRAM and serves the background/sprite fetchers' per-pixel-slot reads. CPU data-port traffic (writes, read-ahead prefetch) is slotted into pixel slots the renderer leaves idle. Sits between the fetchers, the VDP control/data port logic, and a synchronous single-port BRAM.

Parameters:
AW, 14, VRAM address width (16 KB)
DW, 8, VRAM data width

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ce_pix  in  1  pixel-slot enable; asserted at most once every 3 clk_sys
render_req  in  1  fetcher uses this slot (sampled with ce_pix)
render_A  in  AW  fetcher read address (sampled with ce_pix)
render_D  out  DW  read data for the last render slot; stable until the next capture
cpu_addr_set  in  1  pulse: control port loaded a new address
cpu_addr  in  AW  new address (valid with cpu_addr_set)
cpu_prefetch  in  1  with cpu_addr_set: code 0, start a read-ahead
cpu_wr  in  1  pulse: data-port write
cpu_wdata  in  DW  write data (valid with cpu_wr)
cpu_rd  in  1  pulse: data-port read
cpu_rdata  out  DW  read-ahead buffer
cpu_busy  out  1  a CPU access is pending
blank  in  1  display blanked or in vblank (renderer inactive)
mem_A  out  AW  BRAM address
mem_we  out  1  BRAM write enable
mem_din  out  DW  BRAM write data
mem_dout  in  DW  BRAM read data, one clk_sys after mem_A

Behaviour:
- Reset: mem_A=0, mem_we=0, mem_din=0, render_D=0, cpu_rdata=0, cpu_busy=0, addr counter=0, FSM=IDLE. Reset mid-operation drops any pending access; no write is issued.
- Render path, top priority. On ce_pix with render_req=1: mem_A<=render_A, mem_we<=0. Two clk_sys later render_D<=mem_dout. A render_req slot is never given to the CPU.
- Grant: the CPU owns the slot on ce_pix with render_req=0. The issuing cycle is one clk_sys; mem_we pulses for exactly that cycle.
- CPU FSM states: IDLE, WR_PEND, RD_PEND, RD_WAIT1, RD_WAIT2.
  - cpu_wr: latch {addr, cpu_wdata}, set cpu_rdata<=cpu_wdata (the buffer mirrors writes), addr<=addr+1, go to WR_PEND.
  - WR_PEND plus grant: mem_A<=latched addr, mem_we<=1, mem_din<=data, go to IDLE.
  - cpu_rd: cpu_rdata is already the value to return. Latch addr, addr<=addr+1, go to RD_PEND.
  - cpu_addr_set: addr<=cpu_addr. If cpu_prefetch=1, latch cpu_addr, addr<=cpu_addr+1, go to RD_PEND.
  - RD_PEND plus grant: mem_A<=latched addr, go to RD_WAIT1, then RD_WAIT2. At RD_WAIT2, cpu_rdata<=mem_dout and go to IDLE.
- cpu_busy=1 in every state except IDLE.
- Address arithmetic is modulo 2^AW: 0x3FFF+1=0x0000.
- New request while busy:
  - It replaces the pending entry; the older access is lost, matching a too-fast CPU on real hardware.
  - The address counter still increments.
  - A cpu_addr_set without prefetch cancels RD_PEND/RD_WAIT*, but a WR_PEND completes at its latched address.
- Same-cycle collisions, by priority: reset, then cpu_addr_set, then cpu_wr, then cpu_rd. Lower-priority pulses in that cycle are ignored.
- The render capture and CPU capture pipelines are independent. render_D is never changed by CPU traffic.

Optional Feature:
VDP_VRAM_BLANK_FASTPATH_EN:
- Defined: while blank=1, the CPU is granted on any clk_sys, not only on ce_pix, provided no render capture is in flight. Write latency during blank drops to 1 clk_sys.
- Undefined: grants happen only on ce_pix slots with render_req=0, regardless of blank.

Decomposition:
- vdp_pkg holds:
  - VRAM_AW/VRAM_DW constants
  - the cpu_state_t enum (IDLE, WR_PEND, RD_PEND, RD_WAIT1, RD_WAIT2)
  - the RENDER_CAPTURE_DLY=2 constant
- One natural sub-module, vdp_vram_cpu_queue: the CPU FSM, address counter and read-ahead buffer. It exposes req/addr/we/data to the arbiter's slot mux and accepts a grant.

Test Plan:
- Render read: BRAM[0x1234]=0xA5, ce_pix with render_req=1 and render_A=0x1234 -> render_D=0xA5 exactly 2 clk_sys later; held until the next render slot.
- CPU write: cpu_addr_set addr=0x3FFF (no prefetch), cpu_wr 0x5A then 0x3C, every other slot idle -> BRAM[0x3FFF]=0x5A and BRAM[0x0000]=0x3C; each mem_we lasts 1 cycle; cpu_rdata=0x3C.
- Prefetch/read: BRAM[0x0100]=0x11, BRAM[0x0101]=0x22, cpu_addr_set 0x0100 with prefetch -> after grant cpu_rdata=0x11. cpu_rd -> cpu_rdata=0x22 after the next grant; the counter reads 0x0102.
- Slot starvation: render_req=1 on every slot for 50 slots with a write pending -> mem_we stays 0 and cpu_busy=1. The first idle slot issues the write.
- Collision/overwrite: cpu_wr 0x01 then cpu_wr 0x02 before any grant at addr 0x0040 -> only BRAM[0x0041]=0x02 is written; BRAM[0x0040] is unchanged.
- Reset mid-pending: reset asserted in WR_PEND -> no mem_we, cpu_busy=0, cpu_rdata=0 on the next cycle.
